instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the CSE-BUBBLE core; sits directly upstream of instruction_memory.
//  Owns the 16-bit PC, drives the memory's combinational read address and captures
//  the returned word into the IF/ID register with its PC and a valid flag.
//  Resolves unconditional jumps in fetch with zero penalty, accepts branch redirects
//  from downstream, and detects the jump-to-self halt idiom.
// PARAMETERS
//  RESET_PC     16'h0000   PC value loaded on reset
//  JUMP_OPCODE  6'b010100  opcode (instr[31:26]) of the unconditional absolute jump
//  CNT_W        16         width of the saturating fetch counter
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      asynchronous, active-low reset
//  imem_addr        out  16     read address to instruction_memory (= pc, combinational)
//  imem_instr       in   32     instruction word returned for imem_addr (same cycle)
//  stall            in   1      hold PC and IF/ID register
//  redirect_valid   in   1      taken branch resolved downstream; flush and load target
//  redirect_target  in   16     absolute target PC for redirect
//  if_instr         out  32     IF/ID: captured instruction
//  if_pc            out  16     IF/ID: PC of if_instr
//  if_valid         out  1      IF/ID: if_instr is a real instruction (0 = bubble)
//  halted           out  1      sticky: jump-to-self fetched
//  fetch_count      out  CNT_W  number of instructions delivered with if_valid=1
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, if_instr=0, if_pc=0, if_valid=0, halted=0,
//   fetch_count=0. After rst_n deasserts, the first edge captures mem[RESET_PC].
//  Is_jump = (imem_instr[31:26]==JUMP_OPCODE); jump target = imem_instr[15:0].
//  Per rising edge, priority high->low:
//   1 redirect_valid: pc<=redirect_target; if_valid<=0; halted<=0; overrides stall.
//     if_instr/if_pc keep their previous values.
//   2 halted: pc holds; if_valid<=0; nothing new captured.
//   3 stall: pc, if_instr, if_pc, if_valid all hold.
//   4 normal: if_instr<=imem_instr; if_pc<=pc; if_valid<=1; fetch_count+=1 (saturates
//     at all-ones); pc <= is_jump ? target : pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
//     If is_jump and target==pc: the jump is still delivered once (if_valid=1), halted<=1,
//     pc stays; thereafter case 2 applies.
//  Latency: one cycle from imem_addr to if_instr. Redirect penalty: one bubble cycle.
//   Unconditional-jump penalty: zero.
//  imem_addr never depends on stall or redirect combinationally; it is pc only.
//  Simultaneous redirect_valid and stall: redirect wins.
//  Simultaneous redirect_valid and halted: redirect wins and clears halted.
//  fetch_count counts only normal-case captures, never bubbles, stalls or redirects.
//  Reset mid-operation: all registers return to reset values asynchronously.
//   Any in-flight IF/ID contents are discarded.
// TESTING
//  1 Reset then run with straight-line mem[0..3]: edges 1..3 give if_pc=0,1,2 and
//    if_valid=1; fetch_count=3.
//  2 stall=1 for 2 cycles after if_pc=2: if_pc stays 2 and imem_addr stays 3.
//    Release: next if_pc=3.
//  3 mem[16]=32'b010100_11111_00000_00000_00000_000101: after if_pc=16 the next if_pc=5,
//    with no bubble.
//  4 redirect_valid=1, target=16'h0011, stall=1 together: next edge gives if_valid=0 and
//    imem_addr=16'h0011. The following edge gives if_pc=16'h0011 and if_valid=1.
//  5 mem[19]=jump 19: edge capturing it gives if_pc=19, if_valid=1, halted=1.
//    Later edges give if_valid=0 and fetch_count frozen. Redirect to 0 clears halted.
//  6 Force pc=16'hFFFF (redirect) with non-jump word: next imem_addr=16'h0000.
//    Pulse rst_n low mid-run: all outputs reset without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage owning the PC and IF/ID register, with zero-penalty
// absolute jumps, downstream redirects and sticky jump-to-self halt detection.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [5:0]  JUMP_OPCODE = 6'b010100,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [15:0]      imem_addr,
   input  logic [31:0]      imem_instr,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [15:0]      redirect_target,
   output logic [31:0]      if_instr,
   output logic [15:0]      if_pc,
   output logic             if_valid,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);
   logic [15:0]      pc_q, pc_d, if_pc_q, if_pc_d;
   logic [31:0]      if_instr_q, if_instr_d;
   logic             if_valid_q, if_valid_d, halted_q, halted_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_jump;
   logic [15:0]      jump_tgt;

   assign is_jump  = imem_instr[31:26] == JUMP_OPCODE;
   assign jump_tgt = imem_instr[15:0];

   always_comb begin
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
      halted_d   = halted_q;
      cnt_d      = cnt_q;
      if (redirect_valid) begin
         pc_d       = redirect_target;
         if_valid_d = 1'b0;
         halted_d   = 1'b0;
      end else if (halted_q) begin
         if_valid_d = 1'b0;
      end else if (!stall) begin
         if_instr_d = imem_instr;
         if_pc_d    = pc_q;
         if_valid_d = 1'b1;
         cnt_d      = &cnt_q ? cnt_q : cnt_q + 1'b1;
         // a jump-to-self lands back on pc_q, so the PC naturally holds once halted
         pc_d       = is_jump ? jump_tgt : pc_q + 16'd1;
         halted_d   = is_jump && (jump_tgt == pc_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         if_valid_q <= 1'b0;
         halted_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
         halted_q   <= halted_d;
         cnt_q      <= cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_valid    = if_valid_q;
   assign halted      = halted_q;
   assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus randomized run against a
// behavioural fetch model; a narrow-counter twin checks counter saturation.
module tb_instr_fetch_unit;
   localparam logic [5:0] JOP = 6'b010100;
   logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redir = 1'b0;
   logic [15:0] tgt = '0;
   logic [15:0] imem_addr, if_pc, addr2, if_pc2;
   logic [31:0] imem_instr, if_instr, instr2, if_instr2;
   logic        if_valid, halted, valid2, halted2;
   logic [15:0] cnt;
   logic [2:0]  cnt2;
   logic [31:0] mem [0:65535];
   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;
   assign imem_instr = mem[imem_addr];
   assign instr2     = mem[addr2];

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .stall(stall), .redirect_valid(redir), .redirect_target(tgt),
      .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .halted(halted),
      .fetch_count(cnt));

   instr_fetch_unit #(.CNT_W(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr2), .imem_instr(instr2),
      .stall(stall), .redirect_valid(redir), .redirect_target(tgt),
      .if_instr(if_instr2), .if_pc(if_pc2), .if_valid(valid2), .halted(halted2),
      .fetch_count(cnt2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Behavioural reference: architectural state advanced by the fetch rules.
   logic [15:0] m_pc, m_ifpc;
   logic [31:0] m_instr;
   logic        m_valid, m_halt;
   int          m_cnt;

   task automatic model_reset();
      m_pc = 16'h0000; m_ifpc = '0; m_instr = '0; m_valid = 0; m_halt = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      logic [31:0] w;
      if (redir) begin
         m_pc = tgt; m_valid = 0; m_halt = 0;
      end else if (m_halt) begin
         m_valid = 0;
      end else if (!stall) begin
         w = mem[m_pc];
         m_instr = w; m_ifpc = m_pc; m_valid = 1; m_cnt++;
         if (w[31:26] == JOP) begin
            if (w[15:0] == m_pc) m_halt = 1;
            m_pc = w[15:0];
         end else m_pc = m_pc + 16'd1;
      end
   endtask

   task automatic step(input logic s, input logic r, input logic [15:0] t);
      stall = s; redir = r; tgt = t;
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        s, r;
      logic [15:0] t;
      logic        ev;
      logic [15:0] epc, eaddr;
      logic        eh;
      int          ecnt;
   } vec_t;
   vec_t vecs [19];

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = {16'h0000, 16'(i)};
      mem[16] = {JOP, 5'h1f, 5'd0, 16'd5};
      mem[19] = {JOP, 10'd0, 16'd19};
      vecs[0]  = '{0, 0, 16'h0000, 1, 16'd0,  16'd1,  0, 1};
      vecs[1]  = '{0, 0, 16'h0000, 1, 16'd1,  16'd2,  0, 2};
      vecs[2]  = '{0, 0, 16'h0000, 1, 16'd2,  16'd3,  0, 3};
      vecs[3]  = '{1, 0, 16'h0000, 1, 16'd2,  16'd3,  0, 3};
      vecs[4]  = '{1, 0, 16'h0000, 1, 16'd2,  16'd3,  0, 3};
      vecs[5]  = '{0, 0, 16'h0000, 1, 16'd3,  16'd4,  0, 4};
      vecs[6]  = '{0, 1, 16'd16,   0, 16'd3,  16'd16, 0, 4};
      vecs[7]  = '{0, 0, 16'h0000, 1, 16'd16, 16'd5,  0, 5};
      vecs[8]  = '{0, 0, 16'h0000, 1, 16'd5,  16'd6,  0, 6};
      vecs[9]  = '{1, 1, 16'h0011, 0, 16'd5,  16'h11, 0, 6};
      vecs[10] = '{0, 0, 16'h0000, 1, 16'h11, 16'd18, 0, 7};
      vecs[11] = '{0, 0, 16'h0000, 1, 16'd18, 16'd19, 0, 8};
      vecs[12] = '{0, 0, 16'h0000, 1, 16'd19, 16'd19, 1, 9};
      vecs[13] = '{0, 0, 16'h0000, 0, 16'd19, 16'd19, 1, 9};
      vecs[14] = '{1, 0, 16'h0000, 0, 16'd19, 16'd19, 1, 9};
      vecs[15] = '{0, 1, 16'h0000, 0, 16'd19, 16'd0,  0, 9};
      vecs[16] = '{0, 0, 16'h0000, 1, 16'd0,  16'd1,  0, 10};
      vecs[17] = '{0, 1, 16'hFFFF, 0, 16'd0,  16'hFFFF, 0, 10};
      vecs[18] = '{0, 0, 16'h0000, 1, 16'hFFFF, 16'h0000, 0, 11};

      model_reset();
      #2;
      chk("rst_addr", 32'(imem_addr), 32'h0);
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_pc", 32'(if_pc), 32'h0);
      chk("rst_valid", 32'(if_valid), 32'h0);
      chk("rst_halt", 32'(halted), 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
      #10 rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         step(vecs[i].s, vecs[i].r, vecs[i].t);
         chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].ev));
         chk($sformatf("v%0d_pc", i), 32'(if_pc), 32'(vecs[i].epc));
         chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].eaddr));
         chk($sformatf("v%0d_halt", i), 32'(halted), 32'(vecs[i].eh));
         chk($sformatf("v%0d_cnt", i), 32'(cnt), 32'(vecs[i].ecnt));
      end
      chk("jump_instr", if_instr, 32'h0000FFFF);

      // Asynchronous reset mid-run: outputs clear with no clock edge in between.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_addr", 32'(imem_addr), 32'h0);
      chk("arst_instr", if_instr, 32'h0);
      chk("arst_pc", 32'(if_pc), 32'h0);
      chk("arst_valid", 32'(if_valid), 32'h0);
      chk("arst_cnt", 32'(cnt), 32'h0);
      #1 rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         if ($urandom_range(0, 3) == 0)
            mem[i] = {JOP, 10'd0, ($urandom_range(0, 7) == 0) ? 16'(i) : 16'($urandom_range(0, 63))};
         else if (mem[i][31:26] == JOP) mem[i][31:26] = 6'd0;
      end
      for (int c = 0; c < 600; c++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
              ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63)));
         chk("r_addr", 32'(imem_addr), 32'(m_pc));
         chk("r_instr", if_instr, m_instr);
         chk("r_pc", 32'(if_pc), 32'(m_ifpc));
         chk("r_valid", 32'(if_valid), 32'(m_valid));
         chk("r_halt", 32'(halted), 32'(m_halt));
         chk("r_cnt", 32'(cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
         chk("r_cnt_sat", 32'(cnt2), 32'((m_cnt > 7) ? 7 : m_cnt));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
